// File: rtl/vilk_io_port.sv
// Buffered I/O port for the DietVilk core: host->core and core->host FWFT FIFOs,
// sticky overflow/underflow flags and an accepted-output counter.

module vilk_io_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    cnt
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               rptr, wptr;

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge CLK) begin
    if (!reset) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (reset && push) mem[wptr] <= wdata;
  end

  assign rdata = (cnt != '0) ? mem[rptr] : '0;
endmodule

module vilk_io_port #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [WIDTH-1:0] cpu_out_data,
  input  logic             cpu_out_we,
  output logic [WIDTH-1:0] cpu_in_data,
  output logic             cpu_in_valid,
  input  logic             cpu_in_re,
  input  logic [WIDTH-1:0] host_in_data,
  input  logic             host_in_valid,
  output logic             host_in_ready,
  output logic [WIDTH-1:0] host_out_data,
  output logic             host_out_valid,
  input  logic             host_out_ready,
  output logic             out_overflow,
  output logic             in_underflow,
  output logic [CNTW-1:0]  out_total
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] in_cnt, out_cnt;
  logic          in_push, in_pop, out_push, out_pop;

  assign cpu_in_valid   = (in_cnt != '0);
  assign host_in_ready  = (in_cnt != CW'(DEPTH));
  assign host_out_valid = (out_cnt != '0);

  assign in_push  = host_in_valid & host_in_ready;
  assign in_pop   = cpu_in_re & cpu_in_valid;
  assign out_pop  = host_out_ready & host_out_valid;
  // a full output FIFO still takes a write when the host frees a slot this cycle
  assign out_push = cpu_out_we & ((out_cnt != CW'(DEPTH)) | out_pop);

  vilk_io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_in (
    .CLK(CLK), .reset(reset), .push(in_push), .wdata(host_in_data),
    .pop(in_pop), .rdata(cpu_in_data), .cnt(in_cnt)
  );

  vilk_io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_out (
    .CLK(CLK), .reset(reset), .push(out_push), .wdata(cpu_out_data),
    .pop(out_pop), .rdata(host_out_data), .cnt(out_cnt)
  );

  always_ff @(posedge CLK) begin
    if (!reset) begin
      out_total    <= '0;
      out_overflow <= 1'b0;
      in_underflow <= 1'b0;
    end else begin
      if (out_push)                 out_total    <= out_total + CNTW'(1);
      if (cpu_out_we && !out_push)  out_overflow <= 1'b1;
      if (cpu_in_re && !cpu_in_valid) in_underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vilk_io_port.sv
// Self-checking bench for vilk_io_port: queue-based reference model compared
// every cycle, plus directed vectors with literal expectations.

module tb_vilk_io_port;
  localparam int W = 16, D = 4, C = 16;

  logic         CLK = 1'b0, reset = 1'b0;
  logic [W-1:0] cpu_out_data = '0, host_in_data = '0;
  logic         cpu_out_we = 0, cpu_in_re = 0, host_in_valid = 0, host_out_ready = 0;
  logic [W-1:0] cpu_in_data, host_out_data;
  logic         cpu_in_valid, host_in_ready, host_out_valid, out_overflow, in_underflow;
  logic [C-1:0] out_total;

  vilk_io_port #(.WIDTH(W), .DEPTH(D), .CNTW(C)) dut (
    .CLK(CLK), .reset(reset),
    .cpu_out_data(cpu_out_data), .cpu_out_we(cpu_out_we),
    .cpu_in_data(cpu_in_data), .cpu_in_valid(cpu_in_valid), .cpu_in_re(cpu_in_re),
    .host_in_data(host_in_data), .host_in_valid(host_in_valid), .host_in_ready(host_in_ready),
    .host_out_data(host_out_data), .host_out_valid(host_out_valid), .host_out_ready(host_out_ready),
    .out_overflow(out_overflow), .in_underflow(in_underflow), .out_total(out_total)
  );

  always #5 CLK = ~CLK;

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: two bounded queues, sticky flags and a wrapping counter
  logic [W-1:0] qin[$], qout[$];
  bit           m_uf, m_of, armed = 0;
  logic [C-1:0] m_total;

  always @(posedge CLK) begin
    if (!reset) begin
      qin.delete(); qout.delete();
      m_uf = 0; m_of = 0; m_total = '0; armed = 1;
    end else if (armed) begin
      bit ipop, ipush, opop, oacc;
      ipop  = cpu_in_re && qin.size() > 0;
      ipush = host_in_valid && qin.size() < D;
      if (cpu_in_re && qin.size() == 0) m_uf = 1;
      opop  = host_out_ready && qout.size() > 0;
      oacc  = cpu_out_we && (qout.size() < D || opop);
      if (cpu_out_we && !oacc) m_of = 1;
      if (ipop) void'(qin.pop_front());
      if (ipush) qin.push_back(host_in_data);
      if (opop) void'(qout.pop_front());
      if (oacc) begin qout.push_back(cpu_out_data); m_total = m_total + 1'b1; end
    end
  end

  always @(negedge CLK) begin
    if (armed) begin
      chk("cpu_in_valid",   32'(cpu_in_valid),   32'(qin.size() != 0));
      chk("cpu_in_data",    32'(cpu_in_data),    32'(qin.size() != 0 ? qin[0] : 16'h0));
      chk("host_in_ready",  32'(host_in_ready),  32'(qin.size() != D));
      chk("host_out_valid", 32'(host_out_valid), 32'(qout.size() != 0));
      chk("host_out_data",  32'(host_out_data),  32'(qout.size() != 0 ? qout[0] : 16'h0));
      chk("out_overflow",   32'(out_overflow),   32'(m_of));
      chk("in_underflow",   32'(in_underflow),   32'(m_uf));
      chk("out_total",      32'(out_total),      32'(m_total));
    end
  end

  task automatic tick(); @(posedge CLK); #1; endtask
  task automatic idle();
    cpu_out_we = 0; cpu_in_re = 0; host_in_valid = 0; host_out_ready = 0;
  endtask
  task automatic do_reset();
    idle(); reset = 0; tick(); reset = 1;
  endtask

  logic [W-1:0] in_words [4] = '{16'h13B0, 16'h0001, 16'h0002, 16'h0003};
  logic [W-1:0] drain_exp[4] = '{16'h0021, 16'h0022, 16'h0023, 16'h0055};
  logic [W-1:0] rin[$], rout[$];

  initial begin
    // reset held two cycles with strobes toggling
    reset = 0;
    for (int i = 0; i < 2; i++) begin
      cpu_out_we = ~cpu_out_we; cpu_in_re = ~cpu_in_re;
      host_in_valid = ~host_in_valid; host_out_ready = ~host_out_ready;
      tick();
    end
    chk("rst cpu_in_valid", 32'(cpu_in_valid), 32'h0);
    chk("rst host_in_ready", 32'(host_in_ready), 32'h1);
    chk("rst host_out_valid", 32'(host_out_valid), 32'h0);
    chk("rst out_total", 32'(out_total), 32'h0);
    idle(); reset = 1; tick();

    // input path: fill then drain
    for (int i = 0; i < 4; i++) begin
      host_in_valid = 1; host_in_data = in_words[i]; tick();
    end
    idle();
    chk("in full ready", 32'(host_in_ready), 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("in order", 32'(cpu_in_data), 32'(in_words[i]));
      cpu_in_re = 1; tick();
    end
    idle();
    chk("in empty valid", 32'(cpu_in_valid), 32'h0);

    // underflow with simultaneous host push
    cpu_in_re = 1; host_in_valid = 1; host_in_data = 16'h00AA; tick(); idle();
    chk("uf flag", 32'(in_underflow), 32'h1);
    chk("uf data", 32'(cpu_in_data), 32'h00AA);
    chk("uf valid", 32'(cpu_in_valid), 32'h1);

    // output overflow
    for (int i = 0; i < 5; i++) begin
      cpu_out_we = 1; cpu_out_data = 16'h0010 + 16'(i); tick();
    end
    idle();
    chk("ovf total", 32'(out_total), 32'd4);
    chk("ovf flag", 32'(out_overflow), 32'h1);
    for (int i = 0; i < 4; i++) begin
      chk("ovf drain", 32'(host_out_data), 32'h10 + 32'(i));
      host_out_ready = 1; tick();
    end
    idle();

    // reset mid-stream discards buffered words
    host_in_valid = 1; host_in_data = 16'h0BAD; cpu_out_we = 1; cpu_out_data = 16'h0BAD; tick();
    do_reset(); tick();
    chk("mid rst in_valid", 32'(cpu_in_valid), 32'h0);
    chk("mid rst out_valid", 32'(host_out_valid), 32'h0);
    chk("mid rst flags", 32'({out_overflow, in_underflow}), 32'h0);

    // full output FIFO with simultaneous pop and write
    for (int i = 0; i < 4; i++) begin
      cpu_out_we = 1; cpu_out_data = 16'h0020 + 16'(i); tick();
    end
    cpu_out_we = 1; cpu_out_data = 16'h0055; host_out_ready = 1; tick(); idle();
    chk("fullpop ovf", 32'(out_overflow), 32'h0);
    chk("fullpop total", 32'(out_total), 32'd5);
    chk("fullpop count", 32'(qout.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("fullpop drain", 32'(host_out_data), 32'(drain_exp[i]));
      host_out_ready = 1; tick();
    end
    idle();

    // wrap: 3*DEPTH+1 words through each FIFO with random handshakes
    do_reset();
    begin
      int si = 0, gi = 0, so = 0, go = 0, cyc = 0;
      while ((gi < 13 || go < 13) && cyc < 2000) begin
        host_in_valid = (si < 13) && ($urandom_range(0, 1) == 1);
        host_in_data  = 16'h1000 + 16'(si);
        if (host_in_valid && host_in_ready) si++;
        cpu_in_re = cpu_in_valid && ($urandom_range(0, 1) == 1);
        if (cpu_in_re) begin rin.push_back(cpu_in_data); gi++; end
        host_out_ready = ($urandom_range(0, 1) == 1);
        if (host_out_ready && host_out_valid) begin rout.push_back(host_out_data); go++; end
        cpu_out_we = (so < 13) && (qout.size() < D) && ($urandom_range(0, 1) == 1);
        cpu_out_data = 16'h2000 + 16'(so);
        if (cpu_out_we) so++;
        tick(); cyc++;
      end
      idle();
      chk("wrap in count", 32'(gi), 32'd13);
      chk("wrap out count", 32'(go), 32'd13);
      for (int i = 0; i < rin.size(); i++)
        chk("wrap in order", 32'(rin[i]), 32'h1000 + 32'(i));
      for (int i = 0; i < rout.size(); i++)
        chk("wrap out order", 32'(rout[i]), 32'h2000 + 32'(i));
      chk("wrap total", 32'(out_total), 32'd13);
      chk("wrap flags", 32'({out_overflow, in_underflow}), 32'h0);
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
